// File: rtl/xbar_pkg.sv
// -----------------------------------------------------------------------------
// xbar_pkg
// Shared constants and types for the buffered 2x2 crossbar scheduler.
//   DEST_*  : destination tag values carried with each word
//   MODE_*  : crossbar setting reported on xbar_mode
//   SRC_*   : source tag reported on outK_src
//   xbar_entry_t : packed FIFO entry {dest, data} for the default payload width
// -----------------------------------------------------------------------------
package xbar_pkg;

    localparam logic DEST_OUT1     = 1'b0;
    localparam logic DEST_OUT2     = 1'b1;

    localparam logic MODE_STRAIGHT = 1'b0;
    localparam logic MODE_CROSS    = 1'b1;

    localparam logic SRC_IN1       = 1'b0;
    localparam logic SRC_IN2       = 1'b1;

    localparam int   XBAR_DATA_W   = 4;

    // The destination tag sits in the MSB, directly above the payload.
    typedef struct packed {
        logic                   dest;
        logic [XBAR_DATA_W-1:0] data;
    } xbar_entry_t;

endpackage

// File: rtl/xbar_in_fifo.sv
// -----------------------------------------------------------------------------
// xbar_in_fifo
// Synchronous per-input FIFO holding {dest, data} words ahead of arbitration.
// Ports:
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset (empties the FIFO)
//   push_i  : write data_i this edge (ignored when full)
//   pop_i   : drop the head word this edge (ignored when empty)
//   data_i  : word to write
//   head_o  : current head word (valid while !empty_o)
//   full_o  : FIFO holds DEPTH words
//   empty_o : FIFO holds no words
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// -----------------------------------------------------------------------------
module xbar_in_fifo
    import xbar_pkg::*;
#(
    parameter int WIDTH = XBAR_DATA_W + 1,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             doPush;
    logic             doPop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rdPtr_q];
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;

    // Pointer and occupancy bookkeeping; a simultaneous push and pop
    // leaves the count unchanged.
    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
        case ({doPush, doPop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: emptiness is tracked by count_q alone.
    always_ff @(posedge clk_i) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

endmodule

// File: rtl/xbar_2x2_sched.sv
// -----------------------------------------------------------------------------
// xbar_2x2_sched
// Buffered 2x2 packet switch front-end. Each input buffers destination-tagged
// words in an xbar_in_fifo; the FIFO heads are arbitrated onto two registered
// outputs, with same-output conflicts resolved round-robin.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   inK_data/inK_dest/inK_valid      : input K word offer (dest 0=out1, 1=out2)
//   inK_ready                        : input K FIFO can accept (registered count)
//   outK_data/outK_src/outK_valid    : registered output K word and its source
//   outK_ready                       : consumer of output K accepts
//   xbar_mode                        : 0 = straight, 1 = cross (last grant)
//   conflict_cnt                     : saturating same-output conflict count
// Optional feature macro: XBAR_CONFLICT_CNT_EN enables conflict_cnt; when
// undefined the port is tied to zero.
// -----------------------------------------------------------------------------
module xbar_2x2_sched
    import xbar_pkg::*;
#(
    parameter int DATA_W     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in1_data,
    input  logic              in1_dest,
    input  logic              in1_valid,
    output logic              in1_ready,
    input  logic [DATA_W-1:0] in2_data,
    input  logic              in2_dest,
    input  logic              in2_valid,
    output logic              in2_ready,
    output logic [DATA_W-1:0] out1_data,
    output logic              out1_src,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic [DATA_W-1:0] out2_data,
    output logic              out2_src,
    output logic              out2_valid,
    input  logic              out2_ready,
    output logic              xbar_mode,
    output logic [CNT_W-1:0]  conflict_cnt
);

    localparam int EW = DATA_W + 1;

    logic [EW-1:0]     head1, head2;
    logic              full1, full2, empty1, empty2;
    logic              push1, push2, pop1, pop2;
    logic              req11, req21, req12, req22;
    logic              free1, free2;
    logic              grant1, grant2;
    logic              grant1Src, grant2Src;

    logic [DATA_W-1:0] out1Data_q, out1Data_d, out2Data_q, out2Data_d;
    logic              out1Src_q, out1Src_d, out2Src_q, out2Src_d;
    logic              out1Valid_q, out1Valid_d, out2Valid_q, out2Valid_d;
    logic              mode_q, mode_d;
    logic              rrPtr_q, rrPtr_d;

    assign in1_ready = !rst && !full1;
    assign in2_ready = !rst && !full2;
    assign push1     = in1_valid && in1_ready;
    assign push2     = in2_valid && in2_ready;

    xbar_in_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push1),
        .pop_i   (pop1),
        .data_i  ({in1_dest, in1_data}),
        .head_o  (head1),
        .full_o  (full1),
        .empty_o (empty1)
    );

    xbar_in_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo2 (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push2),
        .pop_i   (pop2),
        .data_i  ({in2_dest, in2_data}),
        .head_o  (head2),
        .full_o  (full2),
        .empty_o (empty2)
    );

    // reqXY: head of input X is waiting for output Y.
    assign req11 = !empty1 && (head1[DATA_W] == DEST_OUT1);
    assign req21 = !empty2 && (head2[DATA_W] == DEST_OUT1);
    assign req12 = !empty1 && (head1[DATA_W] == DEST_OUT2);
    assign req22 = !empty2 && (head2[DATA_W] == DEST_OUT2);
    assign free1 = !out1Valid_q || out1_ready;
    assign free2 = !out2Valid_q || out2_ready;

    // Per-output arbitration. Both heads can only collide on one output at a
    // time, so a single round-robin pointer serves both outputs; the winner is
    // the input rrPtr_q points at, and the pointer moves to the loser.
    always_comb begin
        grant1    = 1'b0;
        grant2    = 1'b0;
        grant1Src = SRC_IN1;
        grant2Src = SRC_IN1;
        rrPtr_d   = rrPtr_q;
        if (free1) begin
            if (req11 && req21) begin
                grant1    = 1'b1;
                grant1Src = rrPtr_q;
                rrPtr_d   = ~rrPtr_q;
            end else if (req11) begin
                grant1    = 1'b1;
                grant1Src = SRC_IN1;
            end else if (req21) begin
                grant1    = 1'b1;
                grant1Src = SRC_IN2;
            end
        end
        if (free2) begin
            if (req12 && req22) begin
                grant2    = 1'b1;
                grant2Src = rrPtr_q;
                rrPtr_d   = ~rrPtr_q;
            end else if (req12) begin
                grant2    = 1'b1;
                grant2Src = SRC_IN1;
            end else if (req22) begin
                grant2    = 1'b1;
                grant2Src = SRC_IN2;
            end
        end
    end

    assign pop1 = (grant1 && (grant1Src == SRC_IN1)) || (grant2 && (grant2Src == SRC_IN1));
    assign pop2 = (grant1 && (grant1Src == SRC_IN2)) || (grant2 && (grant2Src == SRC_IN2));

    // Output registers load on a grant, otherwise drop valid once consumed.
    // The crossbar mode follows whichever grant happened; dual grants always
    // agree, so looking at out1 first is sufficient.
    always_comb begin
        out1Data_d  = out1Data_q;
        out1Src_d   = out1Src_q;
        out1Valid_d = out1Valid_q;
        out2Data_d  = out2Data_q;
        out2Src_d   = out2Src_q;
        out2Valid_d = out2Valid_q;
        mode_d      = mode_q;
        if (grant1) begin
            out1Data_d  = (grant1Src == SRC_IN2) ? head2[DATA_W-1:0] : head1[DATA_W-1:0];
            out1Src_d   = grant1Src;
            out1Valid_d = 1'b1;
        end else if (out1Valid_q && out1_ready) begin
            out1Valid_d = 1'b0;
        end
        if (grant2) begin
            out2Data_d  = (grant2Src == SRC_IN2) ? head2[DATA_W-1:0] : head1[DATA_W-1:0];
            out2Src_d   = grant2Src;
            out2Valid_d = 1'b1;
        end else if (out2Valid_q && out2_ready) begin
            out2Valid_d = 1'b0;
        end
        if (grant1) begin
            mode_d = (grant1Src == SRC_IN2) ? MODE_CROSS : MODE_STRAIGHT;
        end else if (grant2) begin
            mode_d = (grant2Src == SRC_IN1) ? MODE_CROSS : MODE_STRAIGHT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out1Data_q  <= '0;
            out1Src_q   <= SRC_IN1;
            out1Valid_q <= 1'b0;
            out2Data_q  <= '0;
            out2Src_q   <= SRC_IN1;
            out2Valid_q <= 1'b0;
            mode_q      <= MODE_STRAIGHT;
            rrPtr_q     <= SRC_IN1;
        end else begin
            out1Data_q  <= out1Data_d;
            out1Src_q   <= out1Src_d;
            out1Valid_q <= out1Valid_d;
            out2Data_q  <= out2Data_d;
            out2Src_q   <= out2Src_d;
            out2Valid_q <= out2Valid_d;
            mode_q      <= mode_d;
            rrPtr_q     <= rrPtr_d;
        end
    end

    assign out1_data  = out1Data_q;
    assign out1_src   = out1Src_q;
    assign out1_valid = out1Valid_q;
    assign out2_data  = out2Data_q;
    assign out2_src   = out2Src_q;
    assign out2_valid = out2Valid_q;
    assign xbar_mode  = mode_q;

`ifdef XBAR_CONFLICT_CNT_EN
    logic             conflictHit;
    logic [CNT_W-1:0] conflictCnt_q, conflictCnt_d;

    // A conflict is both heads wanting the same output while it is free.
    assign conflictHit = (free1 && req11 && req21) || (free2 && req12 && req22);

    // Saturating count so a long-running switch never wraps back to zero.
    always_comb begin
        conflictCnt_d = conflictCnt_q;
        if (conflictHit && (conflictCnt_q != {CNT_W{1'b1}})) begin
            conflictCnt_d = conflictCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            conflictCnt_q <= '0;
        end else begin
            conflictCnt_q <= conflictCnt_d;
        end
    end

    assign conflict_cnt = conflictCnt_q;
`else
    assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_xbar_2x2_sched.sv
// -----------------------------------------------------------------------------
// tb_xbar_2x2_sched
// Directed self-checking bench for xbar_2x2_sched: reset, straight flow,
// round-robin conflicts, backpressure to a full FIFO, cross mode, reset in
// the middle of traffic, and a pointer-wrapping stream with random backpressure.
// -----------------------------------------------------------------------------
module tb_xbar_2x2_sched;

    logic       clk;
    logic       rst;
    logic [3:0] in1_data, in2_data;
    logic       in1_dest, in2_dest;
    logic       in1_valid, in2_valid;
    logic       in1_ready, in2_ready;
    logic [3:0] out1_data, out2_data;
    logic       out1_src, out2_src;
    logic       out1_valid, out2_valid;
    logic       out1_ready, out2_ready;
    logic       xbar_mode;
    logic [7:0] conflict_cnt;

    int passCount  = 0;
    int checkCount = 0;
    int conflictStep;

    xbar_2x2_sched #(.DATA_W(4), .FIFO_DEPTH(4), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .in1_data     (in1_data),
        .in1_dest     (in1_dest),
        .in1_valid    (in1_valid),
        .in1_ready    (in1_ready),
        .in2_data     (in2_data),
        .in2_dest     (in2_dest),
        .in2_valid    (in2_valid),
        .in2_ready    (in2_ready),
        .out1_data    (out1_data),
        .out1_src     (out1_src),
        .out1_valid   (out1_valid),
        .out1_ready   (out1_ready),
        .out2_data    (out2_data),
        .out2_src     (out2_src),
        .out2_valid   (out2_valid),
        .out2_ready   (out2_ready),
        .xbar_mode    (xbar_mode),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end else begin
            passCount++;
        end
    endtask

    // Drive both input ports in one call.
    task automatic applyStimulus(input logic v1, input logic [3:0] d1, input logic dst1,
                                 input logic v2, input logic [3:0] d2, input logic dst2);
        in1_valid = v1;
        in1_data  = d1;
        in1_dest  = dst1;
        in2_valid = v2;
        in2_data  = d2;
        in2_dest  = dst2;
    endtask

    // Advance one clock and settle just after the edge.
    task automatic stepClk;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] expQ[$];
        logic [3:0] word;
        int sent;
        int got;

`ifdef XBAR_CONFLICT_CNT_EN
        conflictStep = 1;
`else
        conflictStep = 0;
`endif

        // ---------------- reset ----------------
        rst        = 1'b1;
        out1_ready = 1'b1;
        out2_ready = 1'b1;
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
        stepClk();
        stepClk();
        checkOutput("rstIn1Ready", in1_ready, 0);
        checkOutput("rstIn2Ready", in2_ready, 0);
        checkOutput("rstOut1Valid", out1_valid, 0);
        checkOutput("rstOut2Valid", out2_valid, 0);
        checkOutput("rstMode", xbar_mode, 0);
        checkOutput("rstConflict", conflict_cnt, 0);
        rst = 1'b0;
        #1;
        checkOutput("postRstIn1Ready", in1_ready, 1);

        // ---------------- straight flow ----------------
        applyStimulus(1'b1, 4'h3, 1'b0, 1'b1, 4'hA, 1'b1);
        stepClk();
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
        checkOutput("straightNotYet", out1_valid, 0);
        stepClk();
        checkOutput("straightOut1Data", out1_data, 4'h3);
        checkOutput("straightOut1Src", out1_src, 0);
        checkOutput("straightOut1Valid", out1_valid, 1);
        checkOutput("straightOut2Data", out2_data, 4'hA);
        checkOutput("straightOut2Src", out2_src, 1);
        checkOutput("straightMode", xbar_mode, 0);
        stepClk();
        checkOutput("straightOut1Clear", out1_valid, 0);
        checkOutput("straightOut2Clear", out2_valid, 0);

        // ---------------- conflict, round robin ----------------
        applyStimulus(1'b1, 4'h5, 1'b1, 1'b1, 4'h6, 1'b1);
        stepClk();
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
        stepClk();
        checkOutput("conf1First", out2_data, 4'h5);
        checkOutput("conf1FirstSrc", out2_src, 0);
        checkOutput("conf1Out1Idle", out1_valid, 0);
        checkOutput("conf1Mode", xbar_mode, 1);
        checkOutput("conf1Count", conflict_cnt, conflictStep);
        stepClk();
        checkOutput("conf1Second", out2_data, 4'h6);
        checkOutput("conf1SecondSrc", out2_src, 1);
        checkOutput("conf1SecondMode", xbar_mode, 0);
        applyStimulus(1'b1, 4'h7, 1'b1, 1'b1, 4'h8, 1'b1);
        stepClk();
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
        stepClk();
        checkOutput("conf2FavoursIn2", out2_data, 4'h8);
        checkOutput("conf2FirstSrc", out2_src, 1);
        checkOutput("conf2Count", conflict_cnt, 2 * conflictStep);
        stepClk();
        checkOutput("conf2Second", out2_data, 4'h7);
        checkOutput("conf2SecondSrc", out2_src, 0);
        stepClk();
        checkOutput("conf2Drained", out2_valid, 0);

        // ---------------- backpressure to full ----------------
        out1_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 4'(i + 1), 1'b0, 1'b0, 4'h0, 1'b0);
            stepClk();
        end
        checkOutput("bpHeld", out1_data, 4'h1);
        checkOutput("bpHeldValid", out1_valid, 1);
        checkOutput("bpFullReady", in1_ready, 0);
        applyStimulus(1'b1, 4'h6, 1'b0, 1'b0, 4'h0, 1'b0);
        stepClk();
        checkOutput("bpStillHeld", out1_data, 4'h1);
        checkOutput("bpStillFull", in1_ready, 0);
        out1_ready = 1'b1;
        stepClk();
        checkOutput("bpDrain2", out1_data, 4'h2);
        checkOutput("bpReadyBack", in1_ready, 1);
        stepClk();
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
        checkOutput("bpDrain3", out1_data, 4'h3);
        for (int i = 4; i <= 6; i++) begin
            stepClk();
            checkOutput("bpDrainN", out1_data, i);
            checkOutput("bpDrainValid", out1_valid, 1);
        end
        stepClk();
        checkOutput("bpEmpty", out1_valid, 0);
        checkOutput("bpMode", xbar_mode, 0);

        // ---------------- cross mode ----------------
        applyStimulus(1'b1, 4'h1, 1'b1, 1'b0, 4'h0, 1'b0);
        stepClk();
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
        stepClk();
        checkOutput("crossData", out2_data, 4'h1);
        checkOutput("crossSrc", out2_src, 0);
        checkOutput("crossMode", xbar_mode, 1);
        stepClk();
        checkOutput("crossValidClear", out2_valid, 0);
        checkOutput("crossModeHold", xbar_mode, 1);
        stepClk();
        checkOutput("crossModeHold2", xbar_mode, 1);

        // ---------------- reset mid-traffic ----------------
        out1_ready = 1'b0;
        out2_ready = 1'b0;
        applyStimulus(1'b1, 4'hE, 1'b0, 1'b1, 4'hC, 1'b1);
        stepClk();
        applyStimulus(1'b1, 4'hF, 1'b0, 1'b1, 4'hD, 1'b1);
        stepClk();
        checkOutput("midOut1Loaded", out1_data, 4'hE);
        checkOutput("midOut2Loaded", out2_data, 4'hC);
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("midRstIn1Ready", in1_ready, 0);
        checkOutput("midRstIn2Ready", in2_ready, 0);
        stepClk();
        checkOutput("midRstOut1Valid", out1_valid, 0);
        checkOutput("midRstOut2Valid", out2_valid, 0);
        checkOutput("midRstOut1Data", out1_data, 0);
        checkOutput("midRstOut2Data", out2_data, 0);
        checkOutput("midRstMode", xbar_mode, 0);
        checkOutput("midRstConflict", conflict_cnt, 0);
        rst        = 1'b0;
        out1_ready = 1'b1;
        out2_ready = 1'b1;
        #1;
        checkOutput("midRstIn1Back", in1_ready, 1);
        checkOutput("midRstIn2Back", in2_ready, 1);
        stepClk();
        stepClk();
        checkOutput("midRstNoOld1", out1_valid, 0);
        checkOutput("midRstNoOld2", out2_valid, 0);

        // ---------------- wrap-around stream ----------------
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 300 && got < 12; cyc++) begin
            word = 4'((sent * 5 + 3) % 16);
            applyStimulus(1'b0, 4'h0, 1'b0, (sent < 12), word, 1'b0);
            out1_ready = 1'($urandom_range(0, 1));
            #1;
            if (in2_valid && in2_ready) begin
                expQ.push_back(word);
                sent++;
            end
            if (out1_valid && out1_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("wrapUnexpected", out1_data, 32'hFFFF_FFFF);
                end else begin
                    checkOutput("wrapData", out1_data, expQ.pop_front());
                    checkOutput("wrapSrc", out1_src, 1);
                end
                got++;
            end
            @(posedge clk);
            #1;
        end
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
        checkOutput("wrapCount", got, 12);
        checkOutput("wrapLeftover", expQ.size(), 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
